// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: op encoding, legality check, FSM states.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'd0,
        ALU_OR  = 3'd1,
        ALU_ADD = 3'd2,
        ALU_SUB = 3'd6,
        ALU_SLT = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Callers zero-extend their select field so one check serves any SWIDTH.
    function automatic logic is_legal_op(input logic [31:0] sel);
        logic legal;
        legal = 1'b0;
        if (sel == 32'(ALU_AND) || sel == 32'(ALU_OR) || sel == 32'(ALU_ADD) ||
            sel == 32'(ALU_SUB) || sel == 32'(ALU_SLT))
            legal = 1'b1;
        return legal;
    endfunction

endpackage

// File: rtl/alu_rr_arb.sv
// Two-way round-robin arbiter; last_grant holds the ID of the most recent winner.
module alu_rr_arb (
    input  logic clk,
    input  logic rst_n,
    input  logic req0_valid,
    input  logic req1_valid,
    input  logic update,
    output logic grant0,
    output logic grant1
);

    logic last_grant;

    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_grant);
        grant1 = req1_valid && (!req0_valid || !last_grant);
    end

    // Reset value 1 lets requester 0 win the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant <= 1'b1;
        else if (update)
            last_grant <= grant1;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters, one operation outstanding at a time.
//   state   | meaning
//   IDLE    | grant a requester and accept its operation
//   EXEC    | latched operands drive the ALU; result captured this cycle
//   RESP    | rsp_valid to owner, result held until owner's rsp_ready
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int SWIDTH = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req1_valid,
    output logic              req0_ready,
    output logic              req1_ready,
    input  logic [SWIDTH-1:0] req0_sel,
    input  logic [SWIDTH-1:0] req1_sel,
    input  logic [DWIDTH-1:0] req0_src1,
    input  logic [DWIDTH-1:0] req0_src2,
    input  logic [DWIDTH-1:0] req1_src1,
    input  logic [DWIDTH-1:0] req1_src2,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    input  logic              rsp0_ready,
    input  logic              rsp1_ready,
    output logic [DWIDTH-1:0] rsp_res,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic [SWIDTH-1:0] alu_sel,
    output logic [DWIDTH-1:0] alu_src1,
    output logic [DWIDTH-1:0] alu_src2,
    input  logic [DWIDTH-1:0] alu_res,
    input  logic              alu_res_is_0
);

    state_e            state, state_nxt;
    logic              grant0, grant1;
    logic              accept, exec;
    logic              legal;
    logic [SWIDTH-1:0] sel_mux;
    logic [DWIDTH-1:0] src1_mux, src2_mux;

    logic              owner_q;
    logic [SWIDTH-1:0] sel_q;
    logic [DWIDTH-1:0] src1_q, src2_q, res_q;
    logic              zero_q, err_q;

    alu_rr_arb u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .update     (accept),
        .grant0     (grant0),
        .grant1     (grant1)
    );

    assign sel_mux  = grant1 ? req1_sel  : req0_sel;
    assign src1_mux = grant1 ? req1_src1 : req0_src1;
    assign src2_mux = grant1 ? req1_src2 : req0_src2;
    assign legal    = is_legal_op(32'(sel_mux));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Ready is qualified by rst_n so nothing is offered while reset is held.
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        accept     = 1'b0;
        exec       = 1'b0;
        case (state)
            ST_IDLE: begin
                req0_ready = grant0 && rst_n;
                req1_ready = grant1 && rst_n;
                accept     = (grant0 || grant1) && rst_n;
                if (accept)
                    state_nxt = legal ? ST_EXEC : ST_RESP;
            end
            ST_EXEC: begin
                exec      = 1'b1;
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp0_valid = !owner_q;
                rsp1_valid = owner_q;
                if (owner_q ? rsp1_ready : rsp0_ready)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Illegal ops leave the ALU operand registers untouched and answer with an error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= 1'b0;
            sel_q   <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                owner_q <= grant1;
                if (legal) begin
                    sel_q  <= sel_mux;
                    src1_q <= src1_mux;
                    src2_q <= src2_mux;
                end else begin
                    res_q  <= '0;
                    zero_q <= 1'b0;
                    err_q  <= 1'b1;
                end
            end
            if (exec) begin
                res_q  <= alu_res;
                zero_q <= alu_res_is_0;
                err_q  <= 1'b0;
            end
        end
    end

    assign alu_sel  = sel_q;
    assign alu_src1 = src1_q;
    assign alu_src2 = src2_q;
    assign rsp_res  = res_q;
    assign rsp_zero = zero_q;
    assign rsp_err  = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached to the ALU port.
module tb_alu_arbiter;

    localparam int DWIDTH = 32;
    localparam int SWIDTH = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req0_valid, req1_valid;
    logic              req0_ready, req1_ready;
    logic [SWIDTH-1:0] req0_sel, req1_sel;
    logic [DWIDTH-1:0] req0_src1, req0_src2, req1_src1, req1_src2;
    logic              rsp0_valid, rsp1_valid;
    logic              rsp0_ready, rsp1_ready;
    logic [DWIDTH-1:0] rsp_res;
    logic              rsp_zero, rsp_err;
    logic [SWIDTH-1:0] alu_sel;
    logic [DWIDTH-1:0] alu_src1, alu_src2;
    logic [DWIDTH-1:0] alu_res;
    logic              alu_res_is_0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DWIDTH(DWIDTH), .SWIDTH(SWIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req1_valid   (req1_valid),
        .req0_ready   (req0_ready),
        .req1_ready   (req1_ready),
        .req0_sel     (req0_sel),
        .req1_sel     (req1_sel),
        .req0_src1    (req0_src1),
        .req0_src2    (req0_src2),
        .req1_src1    (req1_src1),
        .req1_src2    (req1_src2),
        .rsp0_valid   (rsp0_valid),
        .rsp1_valid   (rsp1_valid),
        .rsp0_ready   (rsp0_ready),
        .rsp1_ready   (rsp1_ready),
        .rsp_res      (rsp_res),
        .rsp_zero     (rsp_zero),
        .rsp_err      (rsp_err),
        .alu_sel      (alu_sel),
        .alu_src1     (alu_src1),
        .alu_src2     (alu_src2),
        .alu_res      (alu_res),
        .alu_res_is_0 (alu_res_is_0)
    );

    always_comb begin
        alu_res = '0;
        case (alu_sel)
            3'd0: alu_res = alu_src1 & alu_src2;
            3'd1: alu_res = alu_src1 | alu_src2;
            3'd2: alu_res = alu_src1 + alu_src2;
            3'd6: alu_res = alu_src1 - alu_src2;
            3'd7: alu_res = {31'd0, $signed(alu_src1) < $signed(alu_src2)};
            default: alu_res = '0;
        endcase
        alu_res_is_0 = (alu_res == '0);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_sel   = 3'd6;
        req1_sel   = 3'd6;
        req0_src1  = 32'd4;
        req0_src2  = 32'd4;
        req1_src1  = 32'd4;
        req1_src2  = 32'd4;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        chk("rst_rdy0", req0_ready, 0);
        chk("rst_rdy1", req1_ready, 0);
        chk("rst_val0", rsp0_valid, 0);
        chk("rst_val1", rsp1_valid, 0);
        chk("rst_res", rsp_res, 0);
        chk("rst_zero", rsp_zero, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_alu_sel", alu_sel, 0);
        chk("rst_alu_src1", alu_src1, 0);
        chk("rst_alu_src2", alu_src2, 0);

        // Both requesters contend from reset: SUB 4-4 alternating, requester 0 first.
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) begin
            chk("rr_rdy0", req0_ready, (i % 2) == 0);
            chk("rr_rdy1", req1_ready, (i % 2) == 1);
            step();
            step();
            chk("rr_val0", rsp0_valid, (i % 2) == 0);
            chk("rr_val1", rsp1_valid, (i % 2) == 1);
            chk("rr_res", rsp_res, 0);
            chk("rr_zero", rsp_zero, 1);
            chk("rr_err", rsp_err, 0);
            rsp0_ready = 1'b1;
            rsp1_ready = 1'b1;
            step();
            rsp0_ready = 1'b0;
            rsp1_ready = 1'b0;
            #1;
        end

        // req0 ADD 5+3: ready at T, response at T+2.
        req1_valid = 1'b0;
        req0_sel   = 3'd2;
        req0_src1  = 32'd5;
        req0_src2  = 32'd3;
        #1;
        chk("add_rdy0", req0_ready, 1);
        chk("add_rdy1", req1_ready, 0);
        step();
        req0_valid = 1'b0;
        #1;
        chk("add_exec_val0", rsp0_valid, 0);
        chk("add_alu_sel", alu_sel, 2);
        chk("add_alu_src1", alu_src1, 5);
        chk("add_alu_src2", alu_src2, 3);
        step();
        chk("add_val0", rsp0_valid, 1);
        chk("add_res", rsp_res, 8);
        chk("add_zero", rsp_zero, 0);
        chk("add_err", rsp_err, 0);
        rsp0_ready = 1'b1;
        step();
        rsp0_ready = 1'b0;

        // Illegal sel=3 from req1: response at T+1, ALU inputs left from the ADD.
        req1_valid = 1'b1;
        req1_sel   = 3'd3;
        req1_src1  = 32'd9;
        req1_src2  = 32'd9;
        #1;
        chk("ill_rdy1", req1_ready, 1);
        step();
        req1_valid = 1'b0;
        #1;
        chk("ill_val1", rsp1_valid, 1);
        chk("ill_val0", rsp0_valid, 0);
        chk("ill_err", rsp_err, 1);
        chk("ill_res", rsp_res, 0);
        chk("ill_zero", rsp_zero, 0);
        chk("ill_alu_sel", alu_sel, 2);
        chk("ill_alu_src1", alu_src1, 5);
        chk("ill_alu_src2", alu_src2, 3);
        rsp1_ready = 1'b1;
        step();
        rsp1_ready = 1'b0;

        // Backpressure: req0 AND 12&10=8 held in RESP while req1 (OR 3|4=7) waits.
        req0_valid = 1'b1;
        req0_sel   = 3'd0;
        req0_src1  = 32'd12;
        req0_src2  = 32'd10;
        #1;
        chk("bp_rdy0", req0_ready, 1);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_sel   = 3'd1;
        req1_src1  = 32'd3;
        req1_src2  = 32'd4;
        rsp1_ready = 1'b1;
        #1;
        chk("bp_rdy1_exec", req1_ready, 0);
        step();
        for (int k = 0; k < 5; k++) begin
            chk("bp_val0", rsp0_valid, 1);
            chk("bp_res", rsp_res, 8);
            chk("bp_rdy1", req1_ready, 0);
            step();
        end
        chk("bp_val0_held", rsp0_valid, 1);
        rsp1_ready = 1'b0;
        rsp0_ready = 1'b1;
        step();
        rsp0_ready = 1'b0;
        #1;
        chk("bp_rdy1_idle", req1_ready, 1);
        step();
        req1_valid = 1'b0;
        #1;
        step();
        chk("bp_val1", rsp1_valid, 1);
        chk("bp_res1", rsp_res, 7);
        rsp1_ready = 1'b1;
        step();
        rsp1_ready = 1'b0;

        // Reset during EXEC discards the op; first contention afterwards goes to req0.
        req0_valid = 1'b1;
        req0_sel   = 3'd2;
        req0_src1  = 32'd1;
        req0_src2  = 32'd1;
        #1;
        step();
        req0_valid = 1'b0;
        #1;
        chk("mid_alu_src1", alu_src1, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_res", rsp_res, 0);
        chk("mid_rst_alu_sel", alu_sel, 0);
        chk("mid_rst_alu_src1", alu_src1, 0);
        chk("mid_rst_alu_src2", alu_src2, 0);
        chk("mid_rst_val0", rsp0_valid, 0);
        chk("mid_rst_val1", rsp1_valid, 0);
        chk("mid_rst_err", rsp_err, 0);
        chk("mid_rst_zero", rsp_zero, 0);
        step();
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("post_rst_val0", rsp0_valid, 0);
            chk("post_rst_val1", rsp1_valid, 0);
            step();
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("post_rst_rdy0", req0_ready, 1);
        chk("post_rst_rdy1", req1_ready, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
